// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage access unit in front of a word-indexed data memory.
// Turns byte addresses plus access sizes into whole-word accesses. Loads are
// lane-selected, extended and registered. Byte and halfword stores run as a
// two-cycle read-modify-write. Misaligned or reserved-size requests are flagged
// through alignErr and never reach memory.
module load_store_unit #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWrData,
    output logic [31:0] loadData,
    output logic        loadValid,
    output logic        alignErr,
    output logic [31:0] memAddress,
    output logic [31:0] memWrData,
    output logic        memWrite,
    output logic        memRead,
    input  logic [31:0] memReadData
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RMW_WR = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [0:0]           r_state;
    logic [31:0]          r_load_data;
    logic                 r_load_valid;
    logic                 r_align_err;
    logic [31:0]          r_merged;
    logic [ADDR_BITS-1:0] r_idx;

    logic [ADDR_BITS-1:0] w_word_idx;
    logic [1:0]           w_off;
    logic                 w_misaligned;
    logic                 w_accept;
    logic                 w_err;
    logic                 w_ok;
    logic                 w_load;
    logic                 w_store_word;
    logic                 w_store_sub;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load_ext;
    logic [31:0]          w_merged;
    logic                 w_unused;

    // Address split: bits above the word index are dropped, so addresses alias.
    assign w_word_idx = reqAddr[ADDR_BITS+1:2];
    assign w_off      = reqAddr[1:0];
    assign w_unused   = ^{1'b0, reqAddr[31:ADDR_BITS+2]};

    // Reserved size, odd halfword address or non-zero word offset is rejected.
    assign w_misaligned = (reqSize == 2'b11)
                       || ((reqSize == SZ_HALF) && w_off[0])
                       || ((reqSize == SZ_WORD) && (w_off != 2'b00));

    assign reqReady     = (r_state == S_IDLE);
    assign w_accept     = reqValid && reqReady;
    assign w_err        = w_accept && w_misaligned;
    assign w_ok         = w_accept && !w_misaligned;
    assign w_load       = w_ok && !reqWrite;
    assign w_store_word = w_ok && reqWrite && (reqSize == SZ_WORD);
    assign w_store_sub  = w_ok && reqWrite && (reqSize != SZ_WORD);

    // Memory side: the RMW write phase overrides whatever sits on the request port.
    assign memRead    = w_load || w_store_sub;
    assign memWrite   = (r_state == S_RMW_WR) || w_store_word;
    assign memWrData  = (r_state == S_RMW_WR) ? r_merged : reqWrData;
    assign memAddress = (r_state == S_RMW_WR)
                      ? {{(32-ADDR_BITS){1'b0}}, r_idx}
                      : {{(32-ADDR_BITS){1'b0}}, w_word_idx};

    // Little-endian lane selection for loads.
    assign w_byte = memReadData[{w_off, 3'b000} +: 8];
    assign w_half = w_off[1] ? memReadData[31:16] : memReadData[15:0];

    // Extend the selected lane according to size and signedness.
    always_comb begin
        w_load_ext = memReadData;
        case (reqSize)
            SZ_BYTE: w_load_ext = reqUnsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_HALF: w_load_ext = reqUnsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = memReadData;
        endcase
    end

    // Per-byte merge for sub-word stores: a lane takes new data when the
    // access covers it, otherwise keeps the word just read from memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            logic w_sel;
            logic [7:0] w_new;
            assign w_sel = (reqSize == SZ_BYTE) ? (w_off == 2'(gi))
                                                : (w_off[1] == ((gi / 2) != 0));
            assign w_new = ((reqSize == SZ_HALF) && ((gi % 2) != 0)) ? reqWrData[15:8]
                                                                     : reqWrData[7:0];
            assign w_merged[8*gi +: 8] = w_sel ? w_new : memReadData[8*gi +: 8];
        end
    endgenerate

    // State machine: only a sub-word store leaves IDLE, and only for one cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   r_state <= w_store_sub ? S_RMW_WR : S_IDLE;
                S_RMW_WR: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Load result register holds its value between loads; strobes pulse once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_load_data  <= 32'd0;
            r_load_valid <= 1'b0;
            r_align_err  <= 1'b0;
        end else begin
            if (w_load) begin
                r_load_data <= w_load_ext;
            end
            r_load_valid <= w_load;
            r_align_err  <= w_err;
        end
    end

    // Capture the merged word and its index for the RMW write phase.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_merged <= 32'd0;
            r_idx    <= '0;
        end else if (w_store_sub) begin
            r_merged <= w_merged;
            r_idx    <= w_word_idx;
        end
    end

    assign loadData  = r_load_data;
    assign loadValid = r_load_valid;
    assign alignErr  = r_align_err;

endmodule
